wshb_sdram_arbiter: RTL and testbench



---
 rtl/wshb_sdram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_wshb_sdram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_sdram_arbiter.sv
// wshb_sdram_arbiter
// Two-master Wishbone arbiter in front of the single SDRAM slave port.
// Master 0 is the display reader and master 1 is the frame-buffer writer.
// Ownership is granted per Wishbone cycle (cyc). Controls and data are muxed
// combinationally from the owner, and the slave response is routed back to it.
// A hold counter lets a waiting master preempt the owner on an ack boundary.
//
// Optional feature macro: ARB_FIXED_PRIO_EN
//   defined   : master 0 wins every contention; only master 1 can be preempted
//   undefined : round-robin contention (the master that was not granted last
//               wins); preemption is symmetric

module wshb_sdram_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int ADR_W    = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [31:0]      m0_dat_ms,
    input  logic [3:0]       m0_sel,
    output logic [31:0]      m0_dat_sm,
    output logic             m0_ack,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [31:0]      m1_dat_ms,
    input  logic [3:0]       m1_sel,
    output logic [31:0]      m1_dat_sm,
    output logic             m1_ack,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [31:0]      s_dat_ms,
    output logic [3:0]       s_sel,
    input  logic [31:0]      s_dat_sm,
    input  logic             s_ack,

    output logic [1:0]       grant
);

    // The state encoding doubles as the one-hot grant vector (bit0 = m0).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    // Wide enough to hold MAX_HOLD itself; the counter saturates there.
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_last;        // owner of the most recent grant (1 = m1)

    logic             w_hold_hit;    // this ack completes the owner's quota
    logic             w_preempt0;    // m0 owns and must yield to waiting m1
    logic             w_preempt1;    // m1 owns and must yield to waiting m0
    state_t           w_contend_win; // winner when both request from IDLE
    logic             w_grant_change;

    // The current ack is counted too, so the MAX_HOLD-th ack is the last one
    // the owner completes before handing over.
    assign w_hold_hit = s_ack && (r_hold_cnt >= CNT_LAST);

`ifdef ARB_FIXED_PRIO_EN
    // The display reader always wins and is never preempted.
    assign w_contend_win = ST_GNT0;
    assign w_preempt0    = 1'b0;
    assign w_preempt1    = w_hold_hit && m0_cyc;
`else
    // Round-robin: whoever was not granted last wins a tie.
    assign w_contend_win = r_last ? ST_GNT0 : ST_GNT1;
    assign w_preempt0    = w_hold_hit && m1_cyc;
    assign w_preempt1    = w_hold_hit && m0_cyc;
`endif

    assign w_grant_change = (w_state_next != r_state);

    // State register; reset abandons any in-flight transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: grant from IDLE, release on cyc drop, preempt on quota.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    w_state_next = w_contend_win;
                end else if (m0_cyc) begin
                    w_state_next = ST_GNT0;
                end else if (m1_cyc) begin
                    w_state_next = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc) begin
                    w_state_next = m1_cyc ? ST_GNT1 : ST_IDLE;
                end else if (w_preempt0) begin
                    w_state_next = ST_GNT1;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc) begin
                    w_state_next = m0_cyc ? ST_GNT0 : ST_IDLE;
                end else if (w_preempt1) begin
                    w_state_next = ST_GNT0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Hold counter: cleared on every ownership change, saturating ack count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_grant_change) begin
            r_hold_cnt <= '0;
        end else if ((r_state != ST_IDLE) && s_ack && (r_hold_cnt != CNT_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // Round-robin pointer; reset to m1 so m0 wins the first contention.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant_change && (w_state_next == ST_GNT0)) begin
            r_last <= 1'b0;
        end else if (w_grant_change && (w_state_next == ST_GNT1)) begin
            r_last <= 1'b1;
        end
    end

    // Combinational bus mux: owner drives the slave, slave ack goes to owner only.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        case (r_state)
            ST_GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
                m0_ack   = s_ack;
            end
            ST_GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
                m1_ack   = s_ack;
            end
            default: begin
            end
        endcase
    end

    // Read data is fanned out to both masters; only the acked one samples it.
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;
    assign grant     = r_state;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Testbench for wshb_sdram_arbiter (MAX_HOLD = 4).
// Table-driven vectors: each row drives the master cyc/stb and slave ack for
// one cycle and holds the hand-computed grant/cyc/ack expected in that cycle.
// Master 0 is a reader at 0x200 and master 1 a writer at 0x100 (0xDEADBEEF),
// so the muxed slave address/data/selects follow from the expected grant.
// Hand-written sequences cover reset asynchronously asserted mid-transfer.

module tb_wshb_sdram_arbiter;

    localparam int ADR_W = 32;
    localparam logic [31:0] M0_ADR = 32'h0000_0200;
    localparam logic [31:0] M1_ADR = 32'h0000_0100;
    localparam logic [31:0] M0_DAT = 32'hA5A5_0000;
    localparam logic [31:0] M1_DAT = 32'hDEAD_BEEF;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             m0_cyc, m0_stb, m0_we;
    logic [ADR_W-1:0] m0_adr;
    logic [31:0]      m0_dat_ms, m0_dat_sm;
    logic [3:0]       m0_sel;
    logic             m0_ack;
    logic             m1_cyc, m1_stb, m1_we;
    logic [ADR_W-1:0] m1_adr;
    logic [31:0]      m1_dat_ms, m1_dat_sm;
    logic [3:0]       m1_sel;
    logic             m1_ack;
    logic             s_cyc, s_stb, s_we;
    logic [ADR_W-1:0] s_adr;
    logic [31:0]      s_dat_ms, s_dat_sm;
    logic [3:0]       s_sel;
    logic             s_ack;
    logic [1:0]       grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wshb_sdram_arbiter #(.MAX_HOLD(4), .ADR_W(ADR_W)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .m0_cyc    (m0_cyc),
        .m0_stb    (m0_stb),
        .m0_we     (m0_we),
        .m0_adr    (m0_adr),
        .m0_dat_ms (m0_dat_ms),
        .m0_sel    (m0_sel),
        .m0_dat_sm (m0_dat_sm),
        .m0_ack    (m0_ack),
        .m1_cyc    (m1_cyc),
        .m1_stb    (m1_stb),
        .m1_we     (m1_we),
        .m1_adr    (m1_adr),
        .m1_dat_ms (m1_dat_ms),
        .m1_sel    (m1_sel),
        .m1_dat_sm (m1_dat_sm),
        .m1_ack    (m1_ack),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_adr     (s_adr),
        .s_dat_ms  (s_dat_ms),
        .s_sel     (s_sel),
        .s_dat_sm  (s_dat_sm),
        .s_ack     (s_ack),
        .grant     (grant)
    );

    typedef struct {
        logic       m0c, m0s, m1c, m1s, sack;
        logic [1:0] e_grant;
        logic       e_cyc, e_m0ack, e_m1ack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m0c, input logic m0s, input logic m1c,
                                input logic m1s, input logic sack, input logic [1:0] g,
                                input logic cyc, input logic a0, input logic a1);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.sack = sack;
        v.e_grant = g; v.e_cyc = cyc; v.e_m0ack = a0; v.e_m1ack = a1;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic c0, input logic t0, input logic c1, input logic t1,
                         input logic ack, input logic [31:0] sdat);
        m0_cyc = c0; m0_stb = t0;
        m1_cyc = c1; m1_stb = t1;
        s_ack = ack; s_dat_sm = sdat;
    endtask

    // All slave-side and master-side outputs for an expected grant value.
    task automatic chk_all(input int idx, input vec_t v, input logic [31:0] sdat);
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_stb, e_we;
        e_adr = '0; e_dat = '0; e_sel = '0; e_stb = 1'b0; e_we = 1'b0;
        if (v.e_grant == 2'b01) begin
            e_adr = M0_ADR; e_dat = M0_DAT; e_sel = M0_SEL; e_stb = v.m0s; e_we = 1'b0;
        end else if (v.e_grant == 2'b10) begin
            e_adr = M1_ADR; e_dat = M1_DAT; e_sel = M1_SEL; e_stb = v.m1s; e_we = 1'b1;
        end
        chk("grant",     idx, 32'(grant),  32'(v.e_grant));
        chk("s_cyc",     idx, 32'(s_cyc),  32'(v.e_cyc));
        chk("s_stb",     idx, 32'(s_stb),  32'(e_stb));
        chk("s_we",      idx, 32'(s_we),   32'(e_we));
        chk("s_adr",     idx, s_adr,       e_adr);
        chk("s_dat_ms",  idx, s_dat_ms,    e_dat);
        chk("s_sel",     idx, 32'(s_sel),  32'(e_sel));
        chk("m0_ack",    idx, 32'(m0_ack), 32'(v.e_m0ack));
        chk("m1_ack",    idx, 32'(m1_ack), 32'(v.e_m1ack));
        chk("m0_dat_sm", idx, m0_dat_sm,   sdat);
        chk("m1_dat_sm", idx, m1_dat_sm,   sdat);
    endtask

    initial begin
        logic [31:0] sdat;
        rst_n = 1'b0;
        m0_we = 1'b0; m0_adr = M0_ADR; m0_dat_ms = M0_DAT; m0_sel = M0_SEL;
        m1_we = 1'b1; m1_adr = M1_ADR; m1_dat_ms = M1_DAT; m1_sel = M1_SEL;
        drive(0, 0, 1, 1, 1, 32'h0);

        // Reset state, with m1 requesting and the slave acking.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", -1, 32'(grant),  32'h0);
        chk("rst_s_cyc", -1, 32'(s_cyc),  32'h0);
        chk("rst_s_adr", -1, s_adr,       32'h0);
        chk("rst_m1ack", -1, 32'(m1_ack), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;

        // Single master m1 write, three-cycle slave ack, then release.
        vecs.push_back(mk(0,0,1,1,0, 2'b00,0,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b10,1,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b10,1,0,0));
        vecs.push_back(mk(0,0,1,1,1, 2'b10,1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 2'b10,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2'b00,0,0,0));
        // First contention after reset: m0 wins; read ack; gapless handover.
        vecs.push_back(mk(1,1,1,1,0, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,1,1,1, 2'b01,1,1,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b01,0,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b10,1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2'b10,0,0,0));
        // Last owner m1, so m0 wins again; then both drop (last = m0).
        vecs.push_back(mk(1,1,1,1,0, 2'b00,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2'b01,0,0,0));
`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: m0 wins despite having been granted last.
        vecs.push_back(mk(1,1,1,1,0, 2'b00,0,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b01,0,0,0));
        // m1 streams while m0 waits: preempted after its 4th ack.
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,1,1,1, 2'b10,1,0,1));
        // m0 streams 20 acks with m1 waiting: never preempted.
        for (int i = 0; i < 20; i++) vecs.push_back(mk(1,1,1,1,1, 2'b01,1,1,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b01,0,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2'b10,1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2'b10,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 2'b00,0,0,0));
`else
        // Round-robin: m0 was last, so m1 wins this contention.
        vecs.push_back(mk(1,1,1,1,0, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 2'b10,1,0,0));
        vecs.push_back(mk(1,1,0,0,0, 2'b10,0,0,0));
        // m0 streams while m1 waits: preempted after its 4th ack.
        vecs.push_back(mk(1,1,1,1,0, 2'b01,1,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,1,1,1, 2'b01,1,1,0));
        // m0 still holds cyc but is stalled while m1 owns the bus.
        vecs.push_back(mk(1,1,1,1,0, 2'b10,1,0,0));
        vecs.push_back(mk(1,1,1,1,1, 2'b10,1,0,1));
        vecs.push_back(mk(1,1,0,0,0, 2'b10,0,0,0));
        // m0 re-granted; stb low while cyc high; ack delivered as cyc drops.
        vecs.push_back(mk(1,0,0,0,0, 2'b01,1,0,0));
        vecs.push_back(mk(0,0,0,0,1, 2'b01,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 2'b00,0,0,0));
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            sdat = 32'h1234_5678 + 32'(i);
            drive(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s, vecs[i].sack, sdat);
            #1;
            $display("step %0d: m0c=%b m1c=%b ack=%b grant=%b s_cyc=%b m0_ack=%b m1_ack=%b",
                     i, m0_cyc, m1_cyc, s_ack, grant, s_cyc, m0_ack, m1_ack);
            chk_all(i, vecs[i], sdat);
        end

        // Reset asserted asynchronously while m1 owns the bus.
        @(negedge clk);
        drive(0, 0, 1, 1, 0, 32'h0);
        @(negedge clk);
        #1;
        chk("pre_rst_grant", 100, 32'(grant), 32'h2);
        chk("pre_rst_s_cyc", 100, 32'(s_cyc), 32'h1);
        #1;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        $display("reset mid-transfer: grant=%b s_cyc=%b m1_ack=%b", grant, s_cyc, m1_ack);
        chk("midrst_grant",  101, 32'(grant),  32'h0);
        chk("midrst_s_cyc",  101, 32'(s_cyc),  32'h0);
        chk("midrst_s_stb",  101, 32'(s_stb),  32'h0);
        chk("midrst_s_adr",  101, s_adr,       32'h0);
        chk("midrst_m1_ack", 101, 32'(m1_ack), 32'h0);
        chk("midrst_m0_ack", 101, 32'(m0_ack), 32'h0);
        @(negedge clk);
        drive(1, 1, 1, 1, 0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_grant_idle", 102, 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        $display("after reset release, both request: grant=%b", grant);
        chk("rel_grant_m0", 103, 32'(grant), 32'h1);
        chk("rel_s_adr",    103, s_adr,      M0_ADR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
